pow5_scheduler: RTL and testbench
=================================

Name: pow5_scheduler

Overview:
- Round-robin scheduler sharing one galois_pow_5 S-box unit between N_REQ requesters, e.g. the Griffin state lanes.
- Each requester uses a valid/ready request channel. Results return on one shared response channel tagged with the requester id.
- The block owns the pow unit's enable, base and synchronous reset.
- A watchdog recovers the unit if done never arrives.

Parameters:
- N_BITS, 254, field element width.
- N_REQ, 3, number of requesters (>=2).
- ID_W, $clog2(N_REQ), response id width (localparam, derived).
- TIMEOUT, 64, cycles allowed in WAIT before an error response (must exceed pow unit latency 40).

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-low reset
- req_valid  in  N_REQ  per-requester request valid
- req_ready  out  N_REQ  per-requester accept; at most one bit high
- req_base  in  N_REQ*N_BITS  packed bases; requester i at [i*N_BITS +: N_BITS]
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accept
- rsp_id  out  ID_W  requester index of the response
- rsp_result  out  N_BITS  base^5 mod p; 0 on error
- rsp_error  out  1  watchdog expired for this response
- busy  out  1  state != IDLE
- pow_reset  out  1  active-high sync reset to the pow unit
- pow_enable  out  1  start pulse to the pow unit
- pow_base  out  N_BITS  base to the pow unit, held stable for the whole operation
- pow_result  in  N_BITS  pow unit result
- pow_done  in  1  pow unit done pulse

Behaviour:
- Reset (reset low, async):
  - State = IDLE, rr pointer = 0, base/id/result registers = 0.
  - rsp_valid = 0, rsp_error = 0, pow_enable = 0.
  - pow_reset = 1; rst counter = 2.
- Post-reset: pow_reset stays 1 for 2 clk edges after reset rises, then 0. IDLE does not grant while pow_reset = 1.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If pow_reset = 0 and any req_valid, grant g = first set index searching ptr, ptr+1, ... mod N_REQ.
  - req_ready[g] = 1 combinationally this cycle; all other req_ready bits are 0.
  - Latch base_q = req_base[g] and id_q = g; go to ISSUE.
  - req_ready is 0 in every other state.
- ISSUE:
  - pow_enable = 1 for exactly this cycle; watchdog = 0; go to WAIT.
- WAIT:
  - pow_enable = 0; watchdog increments each cycle.
  - If pow_done: result_q = pow_result, err_q = 0, go to RESP. pow_done wins if it coincides with expiry.
  - Else if watchdog == TIMEOUT-1: result_q = 0, err_q = 1, pow_reset = 1 for next cycle only, go to RESP.
  - pow_done outside WAIT is ignored.
- RESP:
  - rsp_valid = 1 with rsp_id = id_q, rsp_result = result_q, rsp_error = err_q.
  - All held stable until rsp_ready.
  - On rsp_valid && rsp_ready: ptr = (id_q+1) mod N_REQ, go to IDLE. rsp_valid falls the next cycle.
- pow_base = base_q in all states, registered and stable from ISSUE through WAIT.
- Latency, with accept at cycle T:
  - pow_enable at T+1.
  - rsp_valid at cycle after pow_done, T+42 with the 40-cycle unit.
  - Minimum issue spacing = accept-to-IDLE round trip, one operation in flight.
- Fairness:
  - A requester held valid is served within N_REQ operations.
  - ptr advances only on response handshake, including error responses.
- Reset mid-operation clears everything asynchronously. An in-flight operation is dropped with no response.

Test Plan:
- Base 2 on req 0, rsp_ready = 1 -> req_ready[0] pulses 1 cycle; pow_enable 1 cycle later; rsp id 0, result 32, error 0; busy low after handshake.
- Base p-1 (p = 0x30644e72...0000001) on req 2 -> result p-1, id 2.
- req_valid = 3'b111 held, bases 3/4/5 -> responses in id order 0,1,2 with 243, 1024, 3125; ptr then 0; exactly one req_ready per grant.
- rsp_ready low 10 cycles during RESP -> rsp_valid/id/result stable; no new grant until handshake.
- pow_done stubbed 0, TIMEOUT = 64 -> rsp_error = 1, result 0, exactly 64 cycles after ISSUE; pow_reset pulses 1 cycle; next request completes normally.
- Assert reset low mid-WAIT for 3 cycles -> outputs immediately at reset values; pow_reset high 2 edges after release; no stale response; fresh base 7 -> 16807.

Source files
------------

// File: rtl/pow5_scheduler.sv
// Round-robin scheduler sharing one galois_pow_5 unit between N_REQ requesters.
// A watchdog recovers the unit with an error response when done never arrives.
//
// state | meaning
// IDLE  | waiting for a request, grants round-robin starting at ptr
// ISSUE | one-cycle start pulse to the pow unit
// WAIT  | waiting for pow_done while the watchdog runs
// RESP  | holding the tagged response until rsp_ready

module pow5_scheduler #(
   parameter  int N_BITS  = 254,
   parameter  int N_REQ   = 3,
   parameter  int TIMEOUT = 64,
   localparam int ID_W    = $clog2(N_REQ)
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*N_BITS-1:0] req_base,
   output logic                    rsp_valid,
   input  logic                    rsp_ready,
   output logic [ID_W-1:0]         rsp_id,
   output logic [N_BITS-1:0]       rsp_result,
   output logic                    rsp_error,
   output logic                    busy,
   output logic                    pow_reset,
   output logic                    pow_enable,
   output logic [N_BITS-1:0]       pow_base,
   input  logic [N_BITS-1:0]       pow_result,
   input  logic                    pow_done
);

   localparam int WD_W = $clog2(TIMEOUT);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   logic [ID_W-1:0]   ptr, id_q, gnt_id;
   logic [N_BITS-1:0] base_q, result_q, gnt_base;
   logic              err_q, gnt_found, grant, timeout_hit;
   logic [WD_W-1:0]   wd;
   logic [1:0]        rst_cnt;
   logic              pow_reset_q;

   always_comb begin : arbiter
      int idx;
      idx       = 0;
      gnt_found = 1'b0;
      gnt_id    = '0;
      gnt_base  = '0;
      for (int k = 0; k < N_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N_REQ) idx = idx - N_REQ;
         if (!gnt_found && req_valid[idx]) begin
            gnt_found = 1'b1;
            gnt_id    = ID_W'(idx);
            gnt_base  = req_base[idx*N_BITS +: N_BITS];
         end
      end
   end

   always_comb begin : fsm
      state_nxt   = state;
      req_ready   = '0;
      grant       = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (!pow_reset_q && gnt_found) begin
               req_ready[gnt_id] = 1'b1;
               grant             = 1'b1;
               state_nxt         = ISSUE;
            end
         end
         ISSUE: state_nxt = WAIT;
         WAIT: begin
            // a done arriving on the expiry cycle still wins
            if (pow_done) begin
               state_nxt = RESP;
            end else if (wd == WD_W'(TIMEOUT-1)) begin
               timeout_hit = 1'b1;
               state_nxt   = RESP;
            end
         end
         RESP: if (rsp_ready) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         ptr         <= '0;
         base_q      <= '0;
         id_q        <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         wd          <= '0;
         rst_cnt     <= 2'd2;
         pow_reset_q <= 1'b1;
      end else begin
         state <= state_nxt;
         if (grant) begin
            base_q <= gnt_base;
            id_q   <= gnt_id;
         end
         if (state == ISSUE) wd <= '0;
         else if (state == WAIT) wd <= wd + WD_W'(1);
         if (state == WAIT && pow_done) begin
            result_q <= pow_result;
            err_q    <= 1'b0;
         end else if (timeout_hit) begin
            result_q <= '0;
            err_q    <= 1'b1;
         end
         if (state == RESP && rsp_ready)
            ptr <= (id_q == ID_W'(N_REQ-1)) ? '0 : id_q + ID_W'(1);
         if (rst_cnt != 2'd0) rst_cnt <= rst_cnt - 2'd1;
         // held through the post-reset stretch, one-cycle pulse on watchdog expiry
         pow_reset_q <= (rst_cnt > 2'd1) || timeout_hit;
      end
   end

   assign busy       = (state != IDLE);
   assign pow_enable = (state == ISSUE);
   assign pow_base   = base_q;
   assign pow_reset  = pow_reset_q;
   assign rsp_valid  = (state == RESP);
   assign rsp_id     = id_q;
   assign rsp_result = result_q;
   assign rsp_error  = err_q & (state == RESP);

endmodule

// File: tb/tb_pow5_scheduler.sv
// Randomized scoreboard bench for pow5_scheduler with a behavioural pow unit stub
// and an arbitration/latency reference model kept at transaction level.

module tb_pow5_scheduler;

   localparam int N_BITS  = 254;
   localparam int N_REQ   = 3;
   localparam int TIMEOUT = 64;
   localparam int ID_W    = $clog2(N_REQ);
   localparam logic [253:0] P =
      254'h30644e72e131a029b85045b68181585d2833e84879b9709143e1f593f0000001;

   logic                    clk, reset, rsp_ready, rsp_valid, rsp_error, busy;
   logic                    pow_reset, pow_enable, pow_done;
   logic [N_REQ-1:0]        req_valid, req_ready;
   logic [N_REQ*N_BITS-1:0] req_base_bus;
   logic [ID_W-1:0]         rsp_id;
   logic [N_BITS-1:0]       rsp_result, pow_base, pow_result;
   logic [N_BITS-1:0]       base_arr [N_REQ];

   pow5_scheduler #(.N_BITS(N_BITS), .N_REQ(N_REQ), .TIMEOUT(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .req_base(req_base_bus), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
      .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_error(rsp_error), .busy(busy),
      .pow_reset(pow_reset), .pow_enable(pow_enable), .pow_base(pow_base),
      .pow_result(pow_result), .pow_done(pow_done));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always_comb begin
      req_base_bus = '0;
      for (int i = 0; i < N_REQ; i++) req_base_bus[i*N_BITS +: N_BITS] = base_arr[i];
   end

   function automatic logic [253:0] mulm(input logic [253:0] a, input logic [253:0] b);
      logic [511:0] t;
      t = {258'd0, a} * {258'd0, b};
      t = t % {258'd0, P};
      return t[253:0];
   endfunction

   function automatic logic [253:0] pow5(input logic [253:0] b);
      logic [253:0] b2, b4;
      b2 = mulm(b, b);
      b4 = mulm(b2, b2);
      return mulm(b4, b);
   endfunction

   function automatic logic [253:0] rnd_base();
      logic [255:0] r;
      r = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      r = r % {2'b0, P};
      return r[253:0];
   endfunction

   // shared state: each variable has exactly one writing process
   int cyc = 0;
   int rel_edges = 0;
   int lat_sel, to_err, to_seen;
   logic done_sel, spur_en;
   int acc_cnt [N_REQ];
   int seen    [N_REQ];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge reset)
      if (!reset) rel_edges <= 0;
      else if (rel_edges < 3) rel_edges <= rel_edges + 1;

   // ---------------- pow unit stub ----------------
   int           stub_cnt;
   logic         stub_active;
   logic [253:0] stub_base;

   // ---------------- scoreboard / monitor state ----------------
   typedef struct {
      logic [ID_W-1:0] id;
      logic [253:0]    result;
      logic            err;
   } exp_t;

   exp_t         sb [$];
   exp_t         e;
   int           n_cmp = 0;
   int           n_bad = 0;
   logic         in_flight = 1'b0;
   int           ptr_m = 0;
   int           grant_cyc, exp_cyc, op_lat, g, j;
   logic         op_done_en, fl, hold_v, gfound;
   logic [253:0] op_base, hold_res;
   logic [ID_W-1:0] hold_id;
   logic         hold_err;
   logic [N_REQ-1:0] exp_ready;

   initial begin
      pow_done    = 1'b0;
      pow_result  = '0;
      stub_active = 1'b0;
      stub_cnt    = 0;
      stub_base   = '0;
   end

   always @(negedge clk) begin
      #1;
      pow_done = 1'b0;
      if (pow_reset) begin
         stub_active = 1'b0;
      end else if (pow_enable) begin
         stub_cnt    = op_lat;
         stub_active = op_done_en;
         stub_base   = pow_base;
      end else if (stub_active) begin
         stub_cnt = stub_cnt - 1;
         if (stub_cnt == 0) begin
            pow_done    = 1'b1;
            pow_result  = pow5(stub_base);
            stub_active = 1'b0;
         end
      end else if (spur_en && (!in_flight || cyc >= exp_cyc) && $urandom_range(0, 3) == 0) begin
         // stray done while not waiting must be ignored
         pow_done   = 1'b1;
         pow_result = rnd_base();
      end
   end

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, expv, cyc);
      end
   endtask

   always @(negedge clk) begin
      #2;
      chk("drv_timeout", to_err, to_seen);
      to_seen = to_err;
      if (!reset) begin
         chk("rst_rsp_valid", rsp_valid, 0);
         chk("rst_rsp_error", rsp_error, 0);
         chk("rst_busy", busy, 0);
         chk("rst_pow_enable", pow_enable, 0);
         chk("rst_req_ready", req_ready, 0);
         chk("rst_pow_reset", pow_reset, 1);
         sb.delete();
         in_flight = 1'b0;
         ptr_m     = 0;
         hold_v    = 1'b0;
      end else begin
         fl = in_flight;
         chk("busy", busy, fl);
         chk("pow_reset", pow_reset, (rel_edges < 2) || (fl && !op_done_en && cyc == exp_cyc));
         chk("pow_enable", pow_enable, fl && cyc == grant_cyc + 1);
         chk("rsp_valid", rsp_valid, fl && cyc >= exp_cyc);
         if (fl && cyc > grant_cyc) chk("pow_base", pow_base, op_base);
         if (hold_v) begin
            chk("hold_rsp_id", rsp_id, hold_id);
            chk("hold_rsp_result", rsp_result, hold_res);
            chk("hold_rsp_error", rsp_error, hold_err);
         end
         hold_v   = rsp_valid && !rsp_ready;
         hold_id  = rsp_id;
         hold_res = rsp_result;
         hold_err = rsp_error;
         if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
               chk("sb_size", sb.size(), 1);
            end else begin
               e = sb.pop_front();
               chk("rsp_id", rsp_id, e.id);
               chk("rsp_result", rsp_result, e.result);
               chk("rsp_error", rsp_error, e.err);
               ptr_m = (int'(e.id) + 1) % N_REQ;
            end
            in_flight = 1'b0;
         end
         exp_ready = '0;
         gfound    = 1'b0;
         g         = 0;
         if (!fl && rel_edges >= 2) begin
            for (int k = 0; k < N_REQ; k++) begin
               j = (ptr_m + k) % N_REQ;
               if (!gfound && req_valid[j]) begin
                  gfound = 1'b1;
                  g      = j;
               end
            end
         end
         if (gfound) exp_ready[g] = 1'b1;
         chk("req_ready", req_ready, exp_ready);
         if (gfound) begin
            e.id       = ID_W'(g);
            e.result   = done_sel ? pow5(base_arr[g]) : '0;
            e.err      = !done_sel;
            sb.push_back(e);
            in_flight  = 1'b1;
            grant_cyc  = cyc;
            op_base    = base_arr[g];
            op_lat     = lat_sel;
            op_done_en = done_sel;
            exp_cyc    = cyc + 2 + (done_sel ? lat_sel : TIMEOUT);
            acc_cnt[g] = acc_cnt[g] + 1;
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
      for (int i = 0; i < N_REQ; i++)
         if (acc_cnt[i] != seen[i]) begin
            seen[i]      = acc_cnt[i];
            req_valid[i] = 1'b0;
         end
   endtask

   task automatic req(input int i, input logic [253:0] b);
      base_arr[i]  = b;
      req_valid[i] = 1'b1;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while ((in_flight || req_valid != 0) && n < 2000);
      if (n >= 2000) begin
         $display("FAIL wait_idle: still busy after %0d cycles, required idle", n);
         to_err++;
      end
   endtask

   task automatic wait_rsp();
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!rsp_valid && n < 200);
      if (n >= 200) begin
         $display("FAIL wait_rsp: no rsp_valid after %0d cycles, required 1", n);
         to_err++;
      end
   endtask

   initial begin
      int sel;
      for (int i = 0; i < N_REQ; i++) begin
         acc_cnt[i]  = 0;
         seen[i]     = 0;
         base_arr[i] = '0;
      end
      reset     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = '0;
      lat_sel   = 40;
      done_sel  = 1'b1;
      spur_en   = 1'b0;
      to_err    = 0;
      to_seen   = 0;
      repeat (3) tick();
      reset = 1'b1;
      repeat (3) tick();

      req(0, 254'd2);           wait_idle();
      req(2, P - 254'd1);       wait_idle();
      req(0, 254'd3); req(1, 254'd4); req(2, 254'd5); wait_idle();

      req(1, rnd_base()); rsp_ready = 1'b0;
      wait_rsp();
      req(0, 254'd6);
      repeat (10) tick();
      rsp_ready = 1'b1;
      wait_idle();

      done_sel = 1'b0;
      req(0, rnd_base());
      tick();
      done_sel = 1'b1;
      req(1, 254'd9);
      wait_idle();

      lat_sel = 64;
      req(2, rnd_base()); wait_idle();
      lat_sel = 40;

      req(1, 254'd11);
      repeat (10) tick();
      reset = 1'b0;
      repeat (3) tick();
      reset = 1'b1;
      req(2, 254'd7);
      wait_idle();

      spur_en = 1'b1;
      repeat (3000) begin
         tick();
         for (int i = 0; i < N_REQ; i++)
            if (!req_valid[i] && $urandom_range(0, 3) == 0) begin
               sel = $urandom_range(0, 9);
               req(i, sel == 0 ? 254'd0 : sel == 1 ? 254'd1 : sel == 2 ? P - 254'd1 : rnd_base());
            end
         rsp_ready = ($urandom_range(0, 3) != 0);
         lat_sel   = ($urandom_range(0, 3) == 0) ? $urandom_range(2, 64) : $urandom_range(2, 6);
         done_sel  = ($urandom_range(0, 7) != 0);
      end
      spur_en   = 1'b0;
      rsp_ready = 1'b1;
      done_sel  = 1'b1;
      wait_idle();
      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
